// File: rtl/pwm_capture_if.sv
// Measurement bus driven by pwm_capture toward the duty-ratio control logic.
interface pwm_capture_if #(
    parameter int unsigned CNT_W = 15
);
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic             sample_valid;
    logic             signal_ok;
    logic             stuck_high;
    logic             stuck_low;

    // Capture block drives the results.
    modport master (
        output high_time, period, sample_valid, signal_ok, stuck_high, stuck_low
    );

    // Control logic consumes the results.
    modport slave (
        input high_time, period, sample_valid, signal_ok, stuck_high, stuck_low
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM input measurement: reports high time and rising-to-rising period in clk
// cycles, and flags a stuck-high or stuck-low input after TIMEOUT cycles
// without a rising edge. TIMEOUT must lie in [2, 2^CNT_W-1].
module pwm_capture #(
    parameter int unsigned CNT_W   = 15,
    parameter int unsigned TIMEOUT = 32767
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pwm_in,
    pwm_capture_if.master  m
);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state;
    logic             sync_q;
    logic             s;
    logic             s_d;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;

    logic [CNT_W-1:0] high_time_q;
    logic [CNT_W-1:0] period_q;
    logic             sample_valid_q;
    logic             signal_ok_q;
    logic             stuck_high_q;
    logic             stuck_low_q;

    // Two-flop synchronizer for the asynchronous input, plus one delay flop for edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
            s      <= 1'b0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= pwm_in;
            s      <= sync_q;
            s_d    <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Measurement FSM: counts high and period cycles, publishes on each rise
    // that closes a complete period, and drops to IDLE on timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            per_cnt        <= CNT_ZERO;
            hi_cnt         <= CNT_ZERO;
            high_time_q    <= CNT_ZERO;
            period_q       <= CNT_ZERO;
            sample_valid_q <= 1'b0;
            signal_ok_q    <= 1'b0;
            stuck_high_q   <= 1'b0;
            stuck_low_q    <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    // First rise only opens a period; nothing complete to report yet.
                    if (rise) begin
                        state   <= HIGH;
                        per_cnt <= CNT_ONE;
                        hi_cnt  <= CNT_ONE;
                    end
                end
                HIGH: begin
                    // Timeout is checked first so per_cnt can never pass TIMEOUT.
                    if (per_cnt == TIMEOUT_CNT) begin
                        state        <= IDLE;
                        per_cnt      <= CNT_ZERO;
                        hi_cnt       <= CNT_ZERO;
                        high_time_q  <= CNT_ZERO;
                        period_q     <= CNT_ZERO;
                        signal_ok_q  <= 1'b0;
                        stuck_high_q <= s;
                        stuck_low_q  <= ~s;
                    end else if (fall) begin
                        // The falling cycle still belongs to the period, not to the high time.
                        state   <= LOW;
                        per_cnt <= per_cnt + CNT_ONE;
                    end else begin
                        per_cnt <= per_cnt + CNT_ONE;
                        if (s) begin
                            hi_cnt <= hi_cnt + CNT_ONE;
                        end
                    end
                end
                LOW: begin
                    // A rise on the timeout cycle still closes a valid period.
                    if (rise) begin
                        state          <= HIGH;
                        high_time_q    <= hi_cnt;
                        period_q       <= per_cnt;
                        sample_valid_q <= 1'b1;
                        signal_ok_q    <= 1'b1;
                        stuck_high_q   <= 1'b0;
                        stuck_low_q    <= 1'b0;
                        per_cnt        <= CNT_ONE;
                        hi_cnt         <= CNT_ONE;
                    end else if (per_cnt == TIMEOUT_CNT) begin
                        state        <= IDLE;
                        per_cnt      <= CNT_ZERO;
                        hi_cnt       <= CNT_ZERO;
                        high_time_q  <= CNT_ZERO;
                        period_q     <= CNT_ZERO;
                        signal_ok_q  <= 1'b0;
                        stuck_high_q <= s;
                        stuck_low_q  <= ~s;
                    end else begin
                        per_cnt <= per_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    per_cnt <= CNT_ZERO;
                    hi_cnt  <= CNT_ZERO;
                end
            endcase
        end
    end

    assign m.high_time    = high_time_q;
    assign m.period       = period_q;
    assign m.sample_valid = sample_valid_q;
    assign m.signal_ok    = signal_ok_q;
    assign m.stuck_high   = stuck_high_q;
    assign m.stuck_low    = stuck_low_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: PWM segments from a table, expected publish/timeout
// events queued at drive time and matched when the DUT reports them.
module tb_pwm_capture;

    localparam int unsigned CNT_W   = 15;
    localparam int unsigned TIMEOUT = 100;
    localparam int          LAT     = 3;

    typedef struct {
        bit is_sample;
        int cyc;
        int ht;
        int per;
        bit ok;
        bit sh;
        bit sl;
    } ev_t;

    typedef struct {
        int h;
        int l;
        int reps;
        int exp_ht;
        int exp_per;
        bit exp_to;
        bit exp_sh;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm_in = 1'b0;
    int   cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    ev_t evq[$];
    bit  armed = 1'b0;
    int  pend_ht = 0;
    int  pend_per = 0;

    int  held_ht = 0;
    int  held_per = 0;
    bit  held_ok = 1'b0;
    bit  held_sh = 1'b0;
    bit  held_sl = 1'b0;
    logic [1:0] prev_flags = 2'b00;

    pwm_capture_if #(.CNT_W(CNT_W)) bus ();

    pwm_capture #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .m      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Drive one PWM period (rise, h high, l low) and queue what the DUT must report.
    task automatic run_seg(input int h, input int l, input int eh, input int ep,
                           input bit to, input bit tsh);
        int start;
        ev_t e;
        start = cyc;
        if (armed) begin
            e = '{1'b1, start + LAT, pend_ht, pend_per, 1'b1, 1'b0, 1'b0};
            evq.push_back(e);
        end
        if (to) begin
            e = '{1'b0, start + LAT + int'(TIMEOUT), 0, 0, 1'b0, tsh, !tsh};
            evq.push_back(e);
            armed = 1'b0;
        end else begin
            armed    = 1'b1;
            pend_ht  = eh;
            pend_per = ep;
        end
        pwm_in = 1'b1;
        repeat (h) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (l) @(posedge clk);
        #1;
    endtask

    // Output monitor: matches reported events against the queue, checks hold otherwise.
    always @(negedge clk) begin
        ev_t e;
        bit  ev;
        logic [1:0] flags;
        if (rst) begin
            held_ht = 0; held_per = 0; held_ok = 1'b0; held_sh = 1'b0; held_sl = 1'b0;
            prev_flags = 2'b00;
        end else begin
            flags = {bus.stuck_high, bus.stuck_low};
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                e = evq.pop_front();
                chk("missed_event_cycle", cyc, e.cyc);
            end
            ev = bus.sample_valid || (flags != prev_flags && flags != 2'b00);
            if (ev) begin
                if (evq.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    e = evq.pop_front();
                    chk("event_cycle",  cyc, e.cyc);
                    chk("sample_valid", int'(bus.sample_valid), int'(e.is_sample));
                    chk("high_time",    int'(bus.high_time), e.ht);
                    chk("period",       int'(bus.period), e.per);
                    chk("signal_ok",    int'(bus.signal_ok), int'(e.ok));
                    chk("stuck_high",   int'(bus.stuck_high), int'(e.sh));
                    chk("stuck_low",    int'(bus.stuck_low), int'(e.sl));
                    held_ht = e.ht; held_per = e.per; held_ok = e.ok;
                    held_sh = e.sh; held_sl = e.sl;
                end
            end else begin
                chk("hold_high_time", int'(bus.high_time), held_ht);
                chk("hold_period",    int'(bus.period), held_per);
                chk("hold_flags",
                    int'({bus.signal_ok, bus.stuck_high, bus.stuck_low}),
                    int'({held_ok, held_sh, held_sl}));
            end
            prev_flags = flags;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl1[9];
        vec_t tbl2[2];

        // {high, low, repeats, expected high_time, expected period, timeout, stuck high}
        tbl1[0] = '{30,  50, 4, 30,  80, 1'b0, 1'b0};
        tbl1[1] = '{1,    1, 6,  1,   2, 1'b0, 1'b0};
        tbl1[2] = '{40,  60, 2, 40, 100, 1'b0, 1'b0};
        tbl1[3] = '{40,  61, 1,  0,   0, 1'b1, 1'b0};
        tbl1[4] = '{20,  30, 3, 20,  50, 1'b0, 1'b0};
        tbl1[5] = '{150, 30, 1,  0,   0, 1'b1, 1'b1};
        tbl1[6] = '{20,  30, 3, 20,  50, 1'b0, 1'b0};
        tbl1[7] = '{20, 130, 1,  0,   0, 1'b1, 1'b0};
        tbl1[8] = '{10,  10, 3, 10,  20, 1'b0, 1'b0};
        tbl2[0] = '{30,  50, 3, 30,  80, 1'b0, 1'b0};
        tbl2[1] = '{5,  200, 1,  0,   0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_outputs",
            int'({bus.high_time, bus.period, bus.sample_valid, bus.signal_ok,
                  bus.stuck_high, bus.stuck_low}), 0);
        repeat (5) @(posedge clk);
        #1;

        foreach (tbl1[i]) begin
            for (int r = 0; r < tbl1[i].reps; r++) begin
                run_seg(tbl1[i].h, tbl1[i].l, tbl1[i].exp_ht, tbl1[i].exp_per,
                        tbl1[i].exp_to, tbl1[i].exp_sh);
            end
        end

        // Partial high period cut short by a one-cycle reset.
        begin
            ev_t e;
            if (armed) begin
                e = '{1'b1, cyc + LAT, pend_ht, pend_per, 1'b1, 1'b0, 1'b0};
                evq.push_back(e);
            end
            pwm_in = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            rst    = 1'b1;
            pwm_in = 1'b0;
            @(posedge clk);
            #1;
            rst   = 1'b0;
            armed = 1'b0;
            chk("mid_high_reset_outputs",
                int'({bus.high_time, bus.period, bus.sample_valid, bus.signal_ok,
                      bus.stuck_high, bus.stuck_low}), 0);
            chk("mid_high_reset_queue", evq.size(), 0);
            repeat (20) @(posedge clk);
            #1;
        end

        foreach (tbl2[i]) begin
            for (int r = 0; r < tbl2[i].reps; r++) begin
                run_seg(tbl2[i].h, tbl2[i].l, tbl2[i].exp_ht, tbl2[i].exp_per,
                        tbl2[i].exp_to, tbl2[i].exp_sh);
            end
        end

        repeat (10) @(posedge clk);
        #1;
        chk("events_outstanding", evq.size(), 0);
        chk("final_stuck_low", int'(bus.stuck_low), 1);
        chk("final_signal_ok", int'(bus.signal_ok), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
